// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the EX-stage multiply/divide unit.
//   - md opcode encoding (also used by the ID-stage decoder)
//   - default busy-cycle counts for multiply and divide
//   - FSM state encoding
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational datapath for the multiply/divide unit.
//   op_i        : md opcode (MD_MULT / MD_MULTU / MD_DIV / MD_DIVU)
//   a_i, b_i    : operands (rs, rt)
//   hi_o, lo_o  : product high/low, or remainder/quotient
//   div_zero_o  : divide op with a zero divisor (result must not commit)
module md_arith
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             div_zero_o
);

   logic               signed_op;
   logic               is_div;
   logic [2*WIDTH-1:0] a_ext;
   logic [2*WIDTH-1:0] b_ext;
   logic [2*WIDTH-1:0] prod;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   b_safe;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic               div_ovf;

   assign signed_op  = (op_i == MD_MULT) || (op_i == MD_DIV);
   assign is_div     = (op_i == MD_DIV)  || (op_i == MD_DIVU);
   assign div_zero_o = is_div && (b_i == '0);

   // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the
   // product are then correct for both signed and unsigned multiply.
   assign a_ext = {{WIDTH{signed_op & a_i[WIDTH-1]}}, a_i};
   assign b_ext = {{WIDTH{signed_op & b_i[WIDTH-1]}}, b_i};
   assign prod  = a_ext * b_ext;

   // Signed divide goes through magnitudes so the core divider is
   // unsigned. The most-negative value's magnitude is still correct
   // when read back as unsigned.
   assign a_neg  = signed_op & a_i[WIDTH-1];
   assign b_neg  = signed_op & b_i[WIDTH-1];
   assign a_mag  = a_neg ? -a_i : a_i;
   assign b_mag  = b_neg ? -b_i : b_i;
   // Keep the divider well defined on a zero divisor; the result is
   // discarded anyway.
   assign b_safe = div_zero_o ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
   assign q_mag  = a_mag / b_safe;
   assign r_mag  = a_mag % b_safe;

   // MIN / -1 cannot be represented; architecturally it yields
   // quotient MIN and remainder 0.
   assign div_ovf = (op_i == MD_DIV) &&
                    (a_i == {1'b1, {(WIDTH-1){1'b0}}}) &&
                    (b_i == {WIDTH{1'b1}});

   always_comb begin
      quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
      rem  = a_neg ? -r_mag : r_mag;
      if (div_ovf) begin
         quot = {1'b1, {(WIDTH-1){1'b0}}};
         rem  = '0;
      end
   end

   always_comb begin
      hi_o = '0;
      lo_o = '0;
      case (op_i)
         MD_MULT, MD_MULTU: begin
            hi_o = prod[2*WIDTH-1:WIDTH];
            lo_o = prod[WIDTH-1:0];
         end
         MD_DIV, MD_DIVU: begin
            hi_o = rem;
            lo_o = quot;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: EX-stage multi-cycle multiply/divide unit owning HI/LO.
//   clk, reset : clock; synchronous active-high reset
//   start      : EX instruction is an md op (one cycle per instruction)
//   op         : md opcode (md_pkg encoding), valid with start
//   src_a/b    : forwarded rs / rt values
//   busy       : multi-cycle op in progress (hazard unit stalls on busy|start)
//   hi_o, lo_o : architectural HI / LO
// The result is computed at the start edge and held in pending registers;
// the countdown only models latency. HI/LO change at the commit edge,
// the same edge busy falls.
module ex_muldiv_unit
   import md_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CW   = ($clog2(MAXC) > 0) ? $clog2(MAXC) : 1;

   md_state_e        state_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] pend_hi_q;
   logic [WIDTH-1:0] pend_lo_q;
   logic             pend_ok_q;   // clear for divide-by-zero: no commit
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic [WIDTH-1:0] ar_hi;
   logic [WIDTH-1:0] ar_lo;
   logic             ar_div_zero;

   md_arith #(
      .WIDTH (WIDTH)
   ) u_arith (
      .op_i       (op),
      .a_i        (src_a),
      .b_i        (src_b),
      .hi_o       (ar_hi),
      .lo_o       (ar_lo),
      .div_zero_o (ar_div_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_ok_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  case (op)
                     MD_MULT, MD_MULTU: begin
                        pend_hi_q <= ar_hi;
                        pend_lo_q <= ar_lo;
                        pend_ok_q <= 1'b1;
                        count_q   <= CW'(MULT_CYCLES - 1);
                        state_q   <= ST_BUSY;
                     end
                     MD_DIV, MD_DIVU: begin
                        pend_hi_q <= ar_hi;
                        pend_lo_q <= ar_lo;
                        pend_ok_q <= ~ar_div_zero;
                        count_q   <= CW'(DIV_CYCLES - 1);
                        state_q   <= ST_BUSY;
                     end
                     MD_MTHI: hi_q <= src_a;
                     MD_MTLO: lo_q <= src_a;
                     default: ;  // undefined opcodes are ignored
                  endcase
               end
            end
            ST_BUSY: begin
               // start is ignored here; the in-flight op runs to completion
               if (count_q != '0) begin
                  count_q <= count_q - CW'(1);
               end else begin
                  if (pend_ok_q) begin
                     hi_q <= pend_hi_q;
                     lo_q <= pend_lo_q;
                  end
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Direct decode of the state flop, so busy is glitch-free.
   assign busy = (state_q == ST_BUSY);
   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
   import md_pkg::*;

   localparam int W  = 32;
   localparam int MC = 5;
   localparam int DC = 10;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] src_a, src_b;
   logic         busy;
   logic [W-1:0] hi_o, lo_o;

   int errors = 0;
   int checks = 0;

   // reference architectural HI/LO
   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   ex_muldiv_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .busy  (busy),
      .hi_o  (hi_o),
      .lo_o  (lo_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Architectural result of an md op, using wide integer arithmetic.
   function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output bit ok);
      longint          sa, sb, p;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = a;
      ub = b;
      ok = 1'b1;
      h  = '0;
      l  = '0;
      case (o)
         MD_MULT:  begin p  = sa * sb; {h, l} = p;  end
         MD_MULTU: begin up = ua * ub; {h, l} = up; end
         MD_DIV: begin
            if (b == 0) ok = 1'b0;
            else begin l = 32'(sa / sb); h = 32'(sa % sb); end
         end
         MD_DIVU: begin
            if (b == 0) ok = 1'b0;
            else begin l = 32'(ua / ub); h = 32'(ua % ub); end
         end
         default: ok = 1'b0;
      endcase
   endfunction

   // Issue a mult/div, check busy and held HI/LO for every busy cycle,
   // then the committed values. inject pulses mthi and a second mult
   // mid-flight; both must be ignored.
   task automatic run_long(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input bit inject);
      logic [31:0] eh, el;
      bit          ok;
      int          n;
      model(o, a, b, eh, el, ok);
      n = (o == MD_MULT || o == MD_MULTU) ? MC : DC;
      op = o; src_a = a; src_b = b; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= n; i++) begin
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check({tag, "_hi_hold"}, hi_o, m_hi);
         check({tag, "_lo_hold"}, lo_o, m_lo);
         if (inject && i == 2) begin start = 1'b1; op = MD_MTHI; src_a = 32'h1234; end
         if (inject && i == 3) begin start = 1'b1; op = MD_MULT; src_a = $urandom; src_b = $urandom; end
         step();
         start = 1'b0;
      end
      if (ok) begin m_hi = eh; m_lo = el; end
      check({tag, "_done_busy"}, 32'(busy), 32'd0);
      check({tag, "_hi"}, hi_o, m_hi);
      check({tag, "_lo"}, lo_o, m_lo);
   endtask

   // Single-cycle op (mthi/mtlo) or an undefined opcode.
   task automatic run_short(input string tag, input logic [2:0] o, input logic [31:0] a);
      op = o; src_a = a; src_b = $urandom; start = 1'b1;
      step();
      start = 1'b0;
      if (o == MD_MTHI) m_hi = a;
      if (o == MD_MTLO) m_lo = a;
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_hi"}, hi_o, m_hi);
      check({tag, "_lo"}, lo_o, m_lo);
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;

      reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
      m_hi = '0; m_lo = '0;
      step();
      step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hi", hi_o, 32'd0);
      check("rst_lo", lo_o, 32'd0);
      reset = 1'b0;
      step();

      // directed
      run_long("mult",  MD_MULT,  32'hFFFF_FFFF, 32'd2, 1'b0);
      check("mult_hi_const", hi_o, 32'hFFFF_FFFF);
      check("mult_lo_const", lo_o, 32'hFFFF_FFFE);
      run_long("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
      check("multu_hi_const", hi_o, 32'h0000_0001);
      run_long("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
      check("div_lo_const", lo_o, 32'hFFFF_FFFD);
      check("div_hi_const", hi_o, 32'hFFFF_FFFF);
      run_long("divu",  MD_DIVU,  32'd7, 32'd2, 1'b0);
      check("divu_lo_const", lo_o, 32'd3);
      run_long("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("divovf_lo_const", lo_o, 32'h8000_0000);
      check("divovf_hi_const", hi_o, 32'd0);
      run_short("mthi", MD_MTHI, 32'h11);
      run_short("mtlo", MD_MTLO, 32'h22);
      run_long("div0",  MD_DIV,  32'h1234_5678, 32'd0, 1'b0);
      check("div0_hi_const", hi_o, 32'h11);
      check("div0_lo_const", lo_o, 32'h22);
      run_long("divu0", MD_DIVU, 32'hDEAD_BEEF, 32'd0, 1'b0);
      run_short("undef6", 3'd6, 32'hAAAA_5555);
      run_short("undef7", 3'd7, 32'h5555_AAAA);

      // reset on the 3rd busy cycle of a divide
      op = MD_DIV; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         check("rstmid_busy", 32'(busy), 32'd1);
         if (i < 3) step();
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_hi = '0; m_lo = '0;
      check("rstmid_busy0", 32'(busy), 32'd0);
      check("rstmid_hi", hi_o, 32'd0);
      check("rstmid_lo", lo_o, 32'd0);
      for (int i = 0; i < DC + 2; i++) begin
         step();
         check("rstmid_after_busy", 32'(busy), 32'd0);
         check("rstmid_after_hi", hi_o, 32'd0);
         check("rstmid_after_lo", lo_o, 32'd0);
      end

      // start while busy is ignored (mthi and a second mult)
      run_long("inject", MD_MULT, 32'd3, 32'd7, 1'b1);
      check("inject_lo_const", lo_o, 32'd21);
      check("inject_hi_const", hi_o, 32'd0);

      // randomized mix
      for (int k = 0; k < 40; k++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: rb = 32'($urandom_range(1, 9));
            2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            3: rb = -32'($urandom_range(1, 9));
            default: ;
         endcase
         if (ro <= 3'd3) run_long("rnd_long", ro, ra, rb, k[0]);
         else            run_short("rnd_short", ro, ra);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, driven from the ID/EX pipeline register outputs after forwarding muxes.
- Owns the HI/LO architectural registers.
- Executes mult/multu/div/divu with fixed latency; executes mthi/mtlo in one cycle.
- Exports busy so the hazard unit can stall ID-stage md/mfhi/mflo instructions.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, busy cycles for mult/multu
DIV_CYCLES, 10, busy cycles for div/divu

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high; sampled on posedge clk
start  in  1  EX instruction is an md op (valid for one cycle per instruction)
op  in  3  md opcode (package encoding), valid only when start=1
src_a  in  WIDTH  forwarded rs value
src_b  in  WIDTH  forwarded rt value
busy  out  1  multi-cycle operation in progress
hi_o  out  WIDTH  current HI (read by mfhi)
lo_o  out  WIDTH  current LO (read by mflo)

Behaviour:
- Reset: on any posedge with reset=1, force state=IDLE, count=0, busy=0, hi_o=0, lo_o=0, and discard any pending result. Reset has priority over every other input.
- States: IDLE, BUSY.
- IDLE + start + op in {MULT, MULTU, DIV, DIVU}:
  - Compute the result from src_a/src_b at this edge into pending_hi/pending_lo.
  - Load count with N-1 (N = MULT_CYCLES or DIV_CYCLES); go to BUSY.
- BUSY:
  - busy=1 from the edge after start for exactly N cycles.
  - Each edge with count!=0 decrements count.
  - On the edge where count==0, commit pending_hi/pending_lo to hi_o/lo_o, go to IDLE, busy=0.
  - New HI/LO values are visible in the same cycle busy falls.
- busy is a registered output: busy = (state==BUSY). The hazard unit stalls on (busy | start).
- IDLE + start + MTHI: hi_o <= src_a at the next edge; lo_o unchanged; busy stays 0.
- IDLE + start + MTLO: lo_o <= src_a at the next edge; hi_o unchanged; busy stays 0.
- start while BUSY: ignored entirely. This includes mthi/mtlo. The in-flight operation is not disturbed.
- Undefined op codes with start=1: ignored, no state change.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
  - MULTU: unsigned 32x32 -> 64; HI=[63:32], LO=[31:0].
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - DIVU: unsigned; LO=quotient, HI=remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0 (DIV or DIVU): busy for the full DIV_CYCLES; HI/LO retain their prior values (no commit).
- hi_o/lo_o change only on reset, mthi/mtlo, or commit. They hold steady during BUSY.

Decomposition:
- Shared package md_pkg:
  - Op encoding: MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5.
  - Default cycle constants (5, 10).
  - State encoding IDLE/BUSY.
- The decoder in the ID stage also uses the op encoding.
- One sub-module, md_arith: combinational 64-bit product and quotient/remainder, including the signed, overflow and divide-by-zero flag logic.
- The top level holds the FSM, countdown counter, pending registers and HI/LO.

Test Plan:
- mult, src_a=0xFFFFFFFF, src_b=2, start for 1 cycle -> busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu, same operands -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- div, -7 (0xFFFFFFF9) / 2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Follow with divu 7/2 -> LO=3, HI=1.
- Preload HI=0x11, LO=0x22 via mthi/mtlo (each takes effect next edge, busy stays 0). Then div x/0 -> busy 10 cycles, HI=0x11 and LO=0x22 unchanged.
- Start div, assert reset on its 3rd busy cycle -> next edge busy=0, HI=LO=0. No commit in any later cycle.
- During an active mult, pulse start with mthi src_a=0x1234 and with a second mult -> both ignored. The original product commits at cycle 5 and HI is not 0x1234.
